// File: rtl/code_phase_mod.sv
// Burst phase/envelope generator: ramps amplitude up/down around a coded burst and streams BPSK-offset carrier phase.
// Phase word registered 1 cycle after i_signal; stream never stalls, tready low only raises sticky o_underrun.
module code_phase_mod #(
   parameter logic [15:0] AMP_MAX = 16'h7FFF,
   parameter int          PH_W    = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_sinc,
   input  logic [15:0]     i_signal,
   input  logic [PH_W-1:0] i_ftw,
   input  logic [15:0]     i_amp_step,
   input  logic            i_clr,
   output logic [PH_W-1:0] o_phase_tdata,
   output logic            o_phase_tvalid,
   input  logic            i_phase_tready,
   output logic [15:0]     o_amp,
   output logic            o_tx_en,
   output logic            o_underrun
);

   typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DOWN} state_t;

   localparam logic [PH_W-1:0] HALF = {1'b1, {(PH_W-1){1'b0}}};

   state_t          state, state_nxt;
   logic [PH_W-1:0] acc, acc_nxt;
   logic [PH_W-1:0] ftw, ftw_nxt;
   logic [15:0]     step, step_nxt;
   logic [15:0]     amp_nxt, amp_up, amp_dn;
   logic [16:0]     up_sum;
   logic            pol, pol_nxt;
   logic            sinc_take;

   // Saturating ramp arithmetic; a zero step jumps straight to the rail.
   always_comb begin
      up_sum = {1'b0, o_amp} + {1'b0, step};
      if (step == 16'd0 || up_sum >= {1'b0, AMP_MAX})
         amp_up = AMP_MAX;
      else
         amp_up = up_sum[15:0];
      if (step == 16'd0 || o_amp <= step)
         amp_dn = 16'd0;
      else
         amp_dn = o_amp - step;
   end

   always_comb begin
      state_nxt = state;
      amp_nxt   = o_amp;
      ftw_nxt   = ftw;
      step_nxt  = step;
      acc_nxt   = acc + ftw;
      sinc_take = 1'b0;
      case (state)
         IDLE: begin
            if (i_sinc) sinc_take = 1'b1;
         end
         RAMP_UP: begin
            amp_nxt = amp_up;
            if (amp_up == AMP_MAX) state_nxt = ON;
         end
         ON: begin
            amp_nxt = AMP_MAX;
            if (i_signal == 16'd0) state_nxt = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            if (i_sinc) begin
               sinc_take = 1'b1;
            end else begin
               amp_nxt = amp_dn;
               if (amp_dn == 16'd0) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A restart keeps the current amplitude and ramps up from there.
      if (sinc_take) begin
         state_nxt = RAMP_UP;
         ftw_nxt   = i_ftw;
         step_nxt  = i_amp_step;
         acc_nxt   = '0;
      end
   end

   // Zero chips carry no sign, so polarity holds through the ramp-down tail.
   assign pol_nxt = (i_signal == 16'd0) ? pol : i_signal[15];

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state          <= IDLE;
         acc            <= '0;
         ftw            <= '0;
         step           <= '0;
         pol            <= 1'b0;
         o_phase_tdata  <= '0;
         o_phase_tvalid <= 1'b0;
         o_amp          <= '0;
         o_tx_en        <= 1'b0;
         o_underrun     <= 1'b0;
      end else begin
         state          <= state_nxt;
         acc            <= acc_nxt;
         ftw            <= ftw_nxt;
         step           <= step_nxt;
         pol            <= pol_nxt;
         o_phase_tdata  <= acc_nxt + (pol_nxt ? HALF : '0);
         o_phase_tvalid <= 1'b1;
         o_amp          <= amp_nxt;
         o_tx_en        <= (state_nxt != IDLE);
         if (o_phase_tvalid && !i_phase_tready)
            o_underrun <= 1'b1;
         else if (i_clr)
            o_underrun <= 1'b0;
      end
   end

endmodule
